// File: rtl/dcache_controller.sv
// Data cache sequencing controller: zero-stall hits, dirty-victim write-back
// and line refill over a single-outstanding request/ack memory port.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  input  logic         sram_hit_i,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_MISS, S_WRITEBACK, S_REFILL, S_REFILL_DONE
  } state_t;

  state_t         state_q;
  logic [26:0]    req_q;       // latched {tag, index} of the missing access
  logic [255:0]   line_q;      // refilled line awaiting install
  logic           mem_en_q;
  logic           mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [255:0]   mem_data_q;  // victim line for write-back

  logic [22:0]    cpu_tag;
  logic [3:0]     cpu_idx;
  logic [7:0]     cpu_bit;
  logic [255:0]   merged;
  logic           unused_addr;

  assign cpu_tag     = cpu_addr_i[31:9];
  assign cpu_idx     = cpu_addr_i[8:5];
  assign cpu_bit     = {cpu_addr_i[4:2], 5'b0};
  assign unused_addr = ^cpu_addr_i[1:0];

  always_comb begin
    merged = sram_data_i;
    merged[cpu_bit +: 32] = cpu_data_i;
  end

  // SRAM/CPU side is combinational so hits complete in the request cycle.
  always_comb begin
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    if (!rst_i) begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i) begin
            sram_enable_o = 1'b1;
            sram_addr_o   = cpu_idx;
            sram_tag_o    = {1'b1, cpu_write_i, cpu_tag};
            if (sram_hit_i) begin
              if (cpu_write_i) begin
                sram_write_o = 1'b1;
                sram_data_o  = merged;
              end else begin
                cpu_data_o = sram_data_i[cpu_bit +: 32];
              end
            end else begin
              cpu_stall_o = 1'b1;
            end
          end
        end
        S_MISS: begin
          cpu_stall_o   = 1'b1;
          sram_enable_o = 1'b1;
          sram_addr_o   = req_q[3:0];
          sram_tag_o    = {2'b00, req_q[26:4]};
        end
        S_REFILL_DONE: begin
          cpu_stall_o   = 1'b1;
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_addr_o   = req_q[3:0];
          sram_tag_o    = {2'b10, req_q[26:4]};
          sram_data_o   = line_q;
        end
        default: cpu_stall_o = 1'b1;
      endcase
    end
  end

  assign mem_enable_o = mem_en_q & ~rst_i;
  assign mem_write_o  = mem_we_q & ~rst_i;
  assign mem_addr_o   = rst_i ? '0 : mem_addr_q;
  assign mem_data_o   = rst_i ? '0 : mem_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      line_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i && !sram_hit_i) begin
            req_q   <= cpu_addr_i[31:5];
            state_q <= S_MISS;
          end
        end
        S_MISS: begin
          mem_en_q <= 1'b1;
          if (sram_tag_i[24] && sram_tag_i[23]) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= {sram_tag_i[22:0], req_q[3:0], 5'b0};
            mem_data_q <= sram_data_i;
            state_q    <= S_WRITEBACK;
          end else begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_q, 5'b0};
            state_q    <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_q, 5'b0};
            state_q    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            line_q   <= mem_data_i;
            mem_en_q <= 1'b0;
            state_q  <= S_REFILL_DONE;
          end
        end
        S_REFILL_DONE: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural 2-way LRU SRAM and latency-driven
// memory around the DUT, table of CPU accesses plus multi-cycle corner cases.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o, sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_hit_i;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i = '0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_hit_i(sram_hit_i), .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = {8'hA5, a[23:0]} + 32'(w);
    return r;
  endfunction

  // SRAM model: 2 ways x 16 sets, one LRU bit per set (index of the LRU way)
  logic [24:0]  m_tag  [2][16];
  logic [255:0] m_data [2][16];
  logic         m_lru  [16];
  logic         model_clr;
  int           sram_wr_cnt = 0;
  logic         h0, h1, sel_way;

  assign h0 = m_tag[0][sram_addr_o][24] && (m_tag[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
  assign h1 = m_tag[1][sram_addr_o][24] && (m_tag[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
  assign sel_way     = h1 ? 1'b1 : (h0 ? 1'b0 : m_lru[sram_addr_o]);
  assign sram_hit_i  = h0 | h1;
  assign sram_tag_i  = m_tag[sel_way][sram_addr_o];
  assign sram_data_i = m_data[sel_way][sram_addr_o];

  always @(posedge clk) begin
    if (model_clr) begin
      for (int s = 0; s < 16; s++) begin
        m_tag[0][s] <= '0; m_tag[1][s] <= '0;
        m_data[0][s] <= '0; m_data[1][s] <= '0;
        m_lru[s] <= 1'b0;
      end
      sram_wr_cnt <= 0;
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        m_tag[sel_way][sram_addr_o]  <= sram_tag_o;
        m_data[sel_way][sram_addr_o] <= sram_data_o;
        m_lru[sram_addr_o]           <= ~sel_way;
        sram_wr_cnt                  <= sram_wr_cnt + 1;
      end else if (sram_hit_i) begin
        m_lru[sram_addr_o] <= ~sel_way;
      end
    end
  end

  // Memory model: ack on the ack_lat-th cycle of an enabled request
  int           ack_lat = 3;
  logic         hold_ack = 1'b0;
  logic         resp_ack = 1'b0;
  logic         man_ack = 1'b0;
  int           wcnt = 0;
  int           wb_cnt = 0, rf_cnt = 0;
  logic [31:0]  wb_addr = '0, rf_addr = '0;
  logic [255:0] wb_data = '0;

  assign mem_ack_i = resp_ack | man_ack;

  always @(negedge clk) begin
    if (mem_enable_o && !hold_ack) begin
      if (wcnt + 1 >= ack_lat) begin
        resp_ack   <= 1'b1;
        mem_data_i <= pat(mem_addr_o);
        wcnt       <= 0;
        if (mem_write_o) begin
          wb_cnt <= wb_cnt + 1; wb_addr <= mem_addr_o; wb_data <= mem_data_o;
        end else begin
          rf_cnt <= rf_cnt + 1; rf_addr <= mem_addr_o;
        end
      end else begin
        resp_ack <= 1'b0;
        wcnt     <= wcnt + 1;
      end
    end else begin
      resp_ack <= 1'b0;
      if (!mem_enable_o) wcnt <= 0;
    end
  end

  int nchk = 0, nerr = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after the completing cycle.
  task automatic do_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int stalls, output logic [31:0] rd);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
    #1;
    stalls = 0;
    while (cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (cpu_stall_o) chki("op_timeout", 1, 0);
    rd = cpu_data_o;
    @(negedge clk);
    cpu_req_i = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    int          exp_wb;
    logic [31:0] exp_wbaddr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           st, wb0, rf0, wr0, n;
    logic [31:0]  rd, a0;
    logic [255:0] exp_line;
    logic         bad;

    vecs[0]  = '{1'b0, 32'h0000_0200, 32'h0,          6, 32'hA500_0200, 0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0204, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0204, 32'h0,          0, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_021C, 32'h0,          0, 32'hA500_0207, 0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,          6, 32'hA500_0400, 0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0600, 32'h0,          9, 32'hA500_0600, 1, 32'h0000_0200};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1234_5678,  6, 32'h0,         0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0,          0, 32'h1234_5678, 0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D,  6, 32'h0,         0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0240, 32'h0,          6, 32'hA500_0240, 0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0244, 32'h0,          0, 32'hA500_0241, 0, 32'h0};

    rst_i = 1'b1; model_clr = 1'b1;
    cpu_req_i = 1'b1; cpu_write_i = 1'b1; cpu_addr_i = 32'h200; cpu_data_i = 32'h1;
    repeat (3) @(negedge clk);
    #1;
    chki("rst_stall", int'(cpu_stall_o), 0);
    chk32("rst_cpu_data", cpu_data_o, 32'h0);
    chki("rst_sram_en", int'(sram_enable_o), 0);
    chki("rst_sram_we", int'(sram_write_o), 0);
    chk32("rst_sram_tag", 32'(sram_tag_o), 32'h0);
    chki("rst_mem_en", int'(mem_enable_o), 0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b0; model_clr = 1'b0; cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    @(negedge clk); #1;
    chki("idle_sram_en", int'(sram_enable_o), 0);
    chki("idle_stall", int'(cpu_stall_o), 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      wb0 = wb_cnt;
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rd);
      chki($sformatf("v%0d_stall", i), st, vecs[i].exp_stall);
      if (!vecs[i].wr) chk32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chki($sformatf("v%0d_wb_count", i), wb_cnt - wb0, vecs[i].exp_wb);
      if (vecs[i].exp_wb != 0) chk32($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].exp_wbaddr);
      if (i == 1) chk32("store_tag_vd", 32'(m_tag[0][0]), 32'h0180_0001);
      if (i == 5) begin
        exp_line = pat(32'h200);
        exp_line[63:32] = 32'hDEAD_BEEF;
        chk256("wb_line", wb_data, exp_line);
      end
    end

    // Refill with ack withheld for 20 cycles
    hold_ack = 1'b1;
    fork
      begin
        do_op(1'b0, 32'h0000_0800, 32'h0, st, rd);
      end
      begin
        n = 0; bad = 1'b0;
        while (!mem_enable_o && n < 50) begin @(negedge clk); #2; n++; end
        chki("hold_enable_seen", int'(mem_enable_o), 1);
        a0 = mem_addr_o;
        for (int k = 0; k < 20; k++) begin
          if (!mem_enable_o || mem_write_o || mem_addr_o !== a0 || !cpu_stall_o) bad = 1'b1;
          @(negedge clk); #2;
        end
        chk32("hold_addr", a0, 32'h0000_0800);
        chki("hold_stable", int'(bad), 0);
        hold_ack = 1'b0;
      end
    join
    chki("hold_stall", st, 27);
    chk32("hold_rdata", rd, 32'hA500_0800);

    // Reset in the second write-back cycle
    wb0 = wb_cnt; wr0 = sram_wr_cnt;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0440;
    #1; n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 50) begin @(negedge clk); #1; n++; end
    chki("wb_entered", int'(mem_enable_o && mem_write_o), 1);
    @(negedge clk);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    #1;
    chki("rst_mid_mem_en", int'(mem_enable_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chki("post_rst_mem_en", int'(mem_enable_o), 0);
    chki("post_rst_stall", int'(cpu_stall_o), 0);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    chki("late_ack_mem_en", int'(mem_enable_o), 0);
    chki("late_ack_stall", int'(cpu_stall_o), 0);
    chki("late_ack_no_wb", wb_cnt - wb0, 0);
    chki("late_ack_no_sram_wr", sram_wr_cnt - wr0, 0);
    @(negedge clk);
    do_op(1'b0, 32'h0000_0440, 32'h0, st, rd);
    chki("rerun_stall", st, 9);
    chk32("rerun_rdata", rd, 32'hA500_0440);
    chk32("rerun_wb_addr", wb_addr, 32'h0000_0040);
    exp_line = pat(32'h40);
    exp_line[31:0] = 32'hCAFE_F00D;
    chk256("rerun_wb_line", wb_data, exp_line);

    // Request dropped during refill
    wr0 = sram_wr_cnt; rf0 = rf_cnt;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0060;
    #1; n = 0;
    while (!mem_enable_o && n < 50) begin @(negedge clk); #1; n++; end
    chki("drop_refill_seen", int'(mem_enable_o), 1);
    cpu_req_i = 1'b0;
    n = 0;
    while (rf_cnt == rf0 && n < 50) begin @(negedge clk); #1; n++; end
    repeat (3) @(negedge clk);
    #1;
    chk32("drop_rf_addr", rf_addr, 32'h0000_0060);
    chki("drop_sram_writes", sram_wr_cnt - wr0, 1);
    chki("drop_stall", int'(cpu_stall_o), 0);
    chki("drop_mem_en", int'(mem_enable_o), 0);
    @(negedge clk);
    do_op(1'b0, 32'h0000_0060, 32'h0, st, rd);
    chki("drop_hit_stall", st, 0);
    chk32("drop_hit_rdata", rd, 32'hA500_0060);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Sequencing controller for the 2-way set-associative, 16-set, 32-byte-line data cache SRAM. Sits between the CPU memory stage and the `dcache_sram` array on one side and the off-chip data memory on the other. Serves word hits without stall, and on a miss runs dirty-victim write-back and line refill through a single-outstanding request/acknowledge memory handshake.

## Interface
- No parameters. Geometry is fixed:
  - address = tag[31:9] (23b), index[8:5] (4b), word[4:2] (3b), byte[1:0] ignored;
  - SRAM tag field = {valid[24], dirty[23], tag[22:0]}.
- `clk_i` in 1: single clock; every register updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cpu_req_i` in 1: CPU access request, held until `cpu_stall_o` is low.
- `cpu_write_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data, valid in the cycle `cpu_req_i & ~cpu_stall_o & ~cpu_write_i`.
- `cpu_stall_o` out 1: CPU must hold the request.
- `sram_enable_o`, `sram_write_o` out 1 each: SRAM access strobes.
- `sram_addr_o` out 4: set index.
- `sram_tag_o` out 25: tag field to compare or write.
- `sram_data_o` out 256: line to write.
- `sram_hit_i` in 1: SRAM lookup result.
- `sram_tag_i` in 25: selected way's tag (the LRU victim on a miss).
- `sram_data_i` in 256: selected way's line (the LRU victim on a miss).
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1 = write-back, 0 = refill read.
- `mem_addr_o` out 32: line address, bits [4:0] = 0.
- `mem_data_o` out 256: write-back line.
- `mem_ack_i` in 1: one-cycle completion pulse.
- `mem_data_i` in 256: refill line, valid with `mem_ack_i`.

## Operation
- SRAM lookup is combinational:
  - the controller drives `sram_addr_o` = index and `sram_tag_o[22:0]` = request tag;
  - hit/tag/data return in the same cycle;
  - an SRAM write commits at the rising edge when `sram_enable_o & sram_write_o` are both high.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- IDLE, `cpu_req_i` = 0: no SRAM or memory activity.
- IDLE, request with `sram_hit_i` = 1:
  - load: `cpu_data_o` = `sram_data_i[word*32 +: 32]`;
  - store: write the line with word `word` replaced by `cpu_data_i`, tag = {1,1,tag};
  - `cpu_stall_o` = 0; stay in IDLE.
- IDLE, request with `sram_hit_i` = 0: `cpu_stall_o` = 1; go to MISS.
- MISS: latch the victim from `sram_tag_i` / `sram_data_i`.
  - valid & dirty: go to WRITEBACK.
  - otherwise: go to REFILL.
- WRITEBACK:
  - `mem_enable_o` = 1, `mem_write_o` = 1;
  - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_data_o` = victim line;
  - on `mem_ack_i`, go to REFILL.
- REFILL:
  - `mem_enable_o` = 1, `mem_write_o` = 0;
  - `mem_addr_o` = {request tag, index, 5'b0};
  - on `mem_ack_i`, register `mem_data_i` and go to REFILL_DONE.
- REFILL_DONE:
  - SRAM write of the refilled line with tag = {1,0,tag}; the SRAM performs victim way selection and LRU update;
  - go to IDLE, where the re-lookup hits and the access completes as a normal hit.
- `cpu_stall_o` = 1 in every state except IDLE.
- Request fields are latched on IDLE→MISS. All later states use the latched copies, not the live CPU inputs.
- If `cpu_req_i` drops during a miss, the sequence still runs to completion (line installed, no CPU write).
- `mem_ack_i` outside WRITEBACK/REFILL is ignored.
- Only one memory request is ever outstanding.

## Timing
- Reset: FSM in IDLE; latched request and victim registers cleared.
  - Outputs while `rst_i` = 1: `cpu_stall_o` = 0, `cpu_data_o` = 0, all `sram_*_o` = 0, `mem_enable_o` = 0, `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0.
  - Reset mid-miss drops `mem_enable_o` the next cycle; a pending ack is discarded.
- Hit: 0 stall cycles; store commits at the end of the request cycle.
- Memory handshake:
  - `mem_enable_o` and `mem_addr_o` / `mem_data_o` / `mem_write_o` rise on a state entry and stay stable until the `mem_ack_i` cycle;
  - `mem_enable_o` is low in the cycle after the ack.
- Clean miss: stall = 1 (IDLE) + 1 (MISS) + N (REFILL, ack on Nth cycle) + 1 (REFILL_DONE) cycles; completes in the IDLE cycle that follows.
- Dirty miss: adds M WRITEBACK cycles (ack on Mth cycle).
- Back-to-back hits: one access per cycle.

## Test plan
- Reset then load 0x0000_0200, memory ack latency 3:
  - expect MISS → REFILL for 3 cycles at 0x0000_0200, stall 6 cycles;
  - `cpu_data_o` = word 0 of the returned line; no WRITEBACK.
- Store 0xDEADBEEF to 0x0000_0204 (hit after the previous test), then load 0x0000_0204:
  - zero stall;
  - data 0xDEADBEEF;
  - SRAM tag written as valid = 1, dirty = 1.
- Fill both ways of set 0 (0x200, 0x400), dirty the LRU way, then load 0x0000_0600:
  - WRITEBACK to that way's address with the modified line, then REFILL from 0x600.
- Hold `mem_ack_i` low for 20 cycles in REFILL:
  - `mem_enable_o` and `mem_addr_o` stable throughout;
  - `cpu_stall_o` = 1 throughout.
- Pulse `rst_i` in the second WRITEBACK cycle:
  - next cycle FSM in IDLE, `mem_enable_o` = 0, `cpu_stall_o` = 0;
  - a late `mem_ack_i` is ignored.
- Drop `cpu_req_i` during REFILL:
  - line still installed;
  - returns to IDLE with no SRAM data write beyond the refill.
